stage_sequencer: RTL

- Parametrised successor to the fixed five-tick pipeline metronome.
- Generates one-cycle stage-advance pulses (ticks) for an N-stage datapath, with a programmable dwell time per stage, stall and flush.
- Selectable mode: sequential single-token (multi-cycle CPU) or overlapped (all stages tick together, pipelined CPU).
- Sits between the instruction/data memory shells, which drive the stall, and the PC, decoder, ALU, data-memory and register-file stage registers, which consume the ticks.

---
 rtl/stage_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// Stage-advance tick generator for an N-stage datapath.
// Supports a per-stage dwell time, stall, flush, and sequential or overlapped operation.
module stage_sequencer #(
   parameter int NUM_STAGES = 5,
   parameter int DWELL_W    = 4,
   parameter int RET_W      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stuck,
   input  logic                          flush,
   input  logic                          mode,
   input  logic [NUM_STAGES*DWELL_W-1:0] dwell,
   output logic [NUM_STAGES-1:0]         tick,
   output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
   output logic                          wrap,
   output logic [RET_W-1:0]              retired,
   output logic                          active_mode
);

   localparam int IDX_W = $clog2(NUM_STAGES);
   localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);

   typedef enum logic {
      MODE_SEQ = 1'b0,
      MODE_OVL = 1'b1
   } mode_e;

   mode_e                  mode_q, mode_d;
   logic [IDX_W-1:0]       stage_q, stage_d;
   logic [DWELL_W-1:0]     cnt_q, cnt_d;
   logic [NUM_STAGES-1:0]  tick_q, tick_d;
   logic                   wrap_q, wrap_d;
   logic [RET_W-1:0]       retired_q, retired_d;

   logic [DWELL_W-1:0]     dwell_field;
   logic                   fire;

   // Overlapped mode always paces on stage 0's dwell field.
   always_comb begin
      dwell_field = dwell[DWELL_W-1:0];
      if (mode_q == MODE_SEQ) begin
         for (int s = 0; s < NUM_STAGES; s++) begin
            if (stage_q == IDX_W'(s)) begin
               dwell_field = dwell[s*DWELL_W +: DWELL_W];
            end
         end
      end
   end

   assign fire = (cnt_q == dwell_field) && !stuck && !flush;

   always_comb begin
      mode_d    = mode_q;
      stage_d   = stage_q;
      cnt_d     = cnt_q;
      tick_d    = '0;
      wrap_d    = 1'b0;
      retired_d = retired_q;

      if (flush) begin
         stage_d = '0;
         cnt_d   = '0;
         mode_d  = mode_e'(mode);
      end else if (stuck) begin
         stage_d = stage_q;
      end else if (fire) begin
         cnt_d = '0;
         if (mode_q == MODE_OVL) begin
            stage_d   = '0;
            tick_d    = '1;
            wrap_d    = 1'b1;
            retired_d = retired_q + RET_W'(1);
            mode_d    = mode_e'(mode);
         end else begin
            tick_d = NUM_STAGES'(1) << stage_q;
            if (stage_q == LAST_STAGE) begin
               stage_d   = '0;
               wrap_d    = 1'b1;
               retired_d = retired_q + RET_W'(1);
               mode_d    = mode_e'(mode);
            end else begin
               stage_d = stage_q + IDX_W'(1);
            end
         end
      end else begin
         // Counting modulo 2^DWELL_W means a dwell lowered below cnt still comes round to equality.
         cnt_d = cnt_q + DWELL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q    <= MODE_SEQ;
         stage_q   <= '0;
         cnt_q     <= '0;
         tick_q    <= '0;
         wrap_q    <= 1'b0;
         retired_q <= '0;
      end else begin
         mode_q    <= mode_d;
         stage_q   <= stage_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
         retired_q <= retired_d;
      end
   end

   assign tick        = tick_q;
   assign stage_idx   = stage_q;
   assign wrap        = wrap_q;
   assign retired     = retired_q;
   assign active_mode = mode_q;

endmodule
